// File: rtl/ucode_sequencer.sv
// Micro-op sequencer between iFetch and decode: passes ordinary instructions through and
// expands each MUL macro into STEPS MSTEP micro-ops followed by one MFIN.
module ucode_sequencer #(
    parameter logic [6:0]  MUL_OPC  = 7'b0010110,
    parameter logic [6:0]  STEP_OPC = 7'b0010111,
    parameter logic [6:0]  FIN_OPC  = 7'b0011000,
    parameter int unsigned STEPS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic        issue_ready,
    input  logic        flush,
    output logic [31:0] uop_out,
    output logic        uop_valid,
    output logic        control,
    output logic [4:0]  step_idx
);

    typedef enum logic [1:0] {StPass, StSeq, StFin} state_e;

    localparam logic [4:0] LastStep = 5'(STEPS - 1);

    state_e      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic        guard_q, guard_d;
    logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0] mpc_q, mpc_d;

    logic is_mul, pc_eq, blocked, detect;

    assign is_mul  = instr_in[31:25] == MUL_OPC;
    assign pc_eq   = pc_in == mpc_q;
    // iFetch keeps showing the finished MUL until it leaves its ucode state
    assign blocked = (state_q == StPass) && instr_valid && is_mul && guard_q && pc_eq;
    assign detect  = (state_q == StPass) && instr_valid && is_mul && !flush &&
                     !(guard_q && pc_eq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StPass;
            step_q  <= 5'd0;
            guard_q <= 1'b0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            mpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            guard_q <= guard_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            mpc_q   <= mpc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        guard_d   = guard_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        mpc_d     = mpc_q;
        uop_out   = instr_in;
        uop_valid = 1'b0;
        control   = 1'b0;
        step_idx  = 5'd0;

        unique case (state_q)
            StPass: begin
                uop_valid = instr_valid;
                if (guard_q && !pc_eq) begin
                    guard_d = 1'b0;
                end
                if (flush) begin
                    uop_valid = 1'b0;
                    guard_d   = 1'b0;
                end else if (blocked) begin
                    uop_valid = 1'b0;
                end else if (detect) begin
                    control   = 1'b1;
                    uop_valid = 1'b0;
                    rd_d      = instr_in[24:20];
                    rs1_d     = instr_in[19:15];
                    rs2_d     = instr_in[14:10];
                    mpc_d     = pc_in;
                    step_d    = 5'd0;
                    guard_d   = 1'b0;
                    state_d   = StSeq;
                end
            end
            StSeq: begin
                uop_out   = {STEP_OPC, rd_q, rs1_q, rs2_q, 5'd0, step_q};
                uop_valid = 1'b1;
                control   = 1'b1;
                step_idx  = step_q;
                if (flush) begin
                    uop_valid = 1'b0;
                    step_d    = 5'd0;
                    guard_d   = 1'b0;
                    state_d   = StPass;
                end else if (issue_ready) begin
                    if (step_q == LastStep) begin
                        state_d = StFin;
                    end else begin
                        step_d = step_q + 5'd1;
                    end
                end
            end
            StFin: begin
                uop_out   = {FIN_OPC, rd_q, rs1_q, rs2_q, 10'd0};
                uop_valid = 1'b1;
                control   = 1'b1;
                if (flush) begin
                    uop_valid = 1'b0;
                    step_d    = 5'd0;
                    guard_d   = 1'b0;
                    state_d   = StPass;
                end else if (issue_ready) begin
                    step_d  = 5'd0;
                    guard_d = 1'b1;
                    state_d = StPass;
                end
            end
            default: state_d = StPass;
        endcase

        // Nothing leaves the block while reset is held
        if (rst) begin
            uop_out   = 32'd0;
            uop_valid = 1'b0;
            control   = 1'b0;
            step_idx  = 5'd0;
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: pass-through, full MUL expansion, stall, guard,
// flush abort and mid-expansion reset.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic [31:0] pc_in;
    logic        issue_ready;
    logic        flush;
    logic [31:0] uop_out;
    logic        uop_valid;
    logic        control;
    logic [4:0]  step_idx;

    int checks = 0;
    int errors = 0;
    int n_uops = 0;
    int n_fin  = 0;

    localparam logic [31:0] MulWord = {7'b0010110, 5'd3, 5'd4, 5'd5, 10'd0};
    localparam logic [31:0] FinWord = 32'h30321400;
    localparam logic [31:0] AddWord = 32'h00B50533;

    ucode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .instr_valid(instr_valid),
        .pc_in      (pc_in),
        .issue_ready(issue_ready),
        .flush      (flush),
        .uop_out    (uop_out),
        .uop_valid  (uop_valid),
        .control    (control),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    // Micro-ops accepted by decode while the fetch is frozen
    always @(negedge clk) begin
        if (!rst && uop_valid && issue_ready && control) begin
            n_uops++;
            if (uop_out == FinWord) n_fin++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mstep(input int i);
        return {7'b0010111, 5'd3, 5'd4, 5'd5, 5'd0, 5'(i)};
    endfunction

    // Check one expected MSTEP cycle at the next negedge
    task automatic expect_step(input int i, input string tag);
        @(negedge clk);
        check({tag, " uop"}, uop_out, mstep(i));
        check({tag, " step_idx"}, 32'(step_idx), 32'(i));
        check({tag, " valid"}, 32'(uop_valid), 32'd1);
        check({tag, " control"}, 32'(control), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        instr_in    = MulWord;
        instr_valid = 1'b1;
        pc_in       = 32'h10;
        issue_ready = 1'b1;
        flush       = 1'b0;

        // Reset held two cycles with a MUL presented
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst valid", 32'(uop_valid), 32'd0);
            check("rst control", 32'(control), 32'd0);
            check("rst step_idx", 32'(step_idx), 32'd0);
            check("rst uop", uop_out, 32'd0);
        end

        // Plain pass-through
        tick();
        rst      = 1'b0;
        instr_in = 32'h12345678;
        pc_in    = 32'h0c;
        @(negedge clk);
        check("pass uop", uop_out, 32'h12345678);
        check("pass valid", 32'(uop_valid), 32'd1);
        check("pass control", 32'(control), 32'd0);

        // Full expansion with decode always ready
        n_uops   = 0;
        n_fin    = 0;
        tick();
        instr_in = MulWord;
        pc_in    = 32'h10;
        @(negedge clk);
        check("detect control", 32'(control), 32'd1);
        check("detect valid", 32'(uop_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_step(i, "seq");
        end
        tick();
        @(negedge clk);
        check("fin uop", uop_out, FinWord);
        check("fin valid", 32'(uop_valid), 32'd1);
        check("fin control", 32'(control), 32'd1);
        check("fin step_idx", 32'(step_idx), 32'd0);

        // Same MUL still presented: guard suppresses re-trigger
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            check("guard valid", 32'(uop_valid), 32'd0);
            check("guard control", 32'(control), 32'd0);
        end
        check("macro uops", 32'(n_uops), 32'd17);
        check("macro fins", 32'(n_fin), 32'd1);

        tick();
        instr_in = AddWord;
        pc_in    = 32'h14;
        @(negedge clk);
        check("next uop", uop_out, AddWord);
        check("next valid", 32'(uop_valid), 32'd1);
        check("next control", 32'(control), 32'd0);

        // Second MUL: stall at step 5, then flush at step 7
        n_uops   = 0;
        n_fin    = 0;
        tick();
        instr_in = MulWord;
        pc_in    = 32'h20;
        @(negedge clk);
        check("mul2 control", 32'(control), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_step(i, "mul2");
        end
        tick();
        issue_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expect_step(5, "stall");
            if (c < 2) tick();
        end
        tick();
        issue_ready = 1'b1;
        expect_step(5, "resume");
        tick();
        expect_step(6, "mul2");
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush valid", 32'(uop_valid), 32'd0);
        check("flush step_idx", 32'(step_idx), 32'd7);
        tick();
        flush    = 1'b0;
        instr_in = AddWord;
        pc_in    = 32'h40;
        @(negedge clk);
        check("postflush control", 32'(control), 32'd0);
        check("postflush step_idx", 32'(step_idx), 32'd0);
        check("postflush uop", uop_out, AddWord);
        check("postflush valid", 32'(uop_valid), 32'd1);
        check("aborted uops", 32'(n_uops), 32'd7);
        check("aborted fins", 32'(n_fin), 32'd0);

        // Flush beats detect in pass state
        tick();
        instr_in = MulWord;
        pc_in    = 32'h50;
        flush    = 1'b1;
        @(negedge clk);
        check("flushdet control", 32'(control), 32'd0);
        check("flushdet valid", 32'(uop_valid), 32'd0);

        // Reset in the middle of an expansion
        tick();
        flush = 1'b0;
        tick();
        expect_step(0, "mul3");
        tick();
        expect_step(1, "mul3");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst valid", 32'(uop_valid), 32'd0);
        check("midrst control", 32'(control), 32'd0);
        tick();
        rst      = 1'b0;
        instr_in = 32'h12345678;
        pc_in    = 32'h60;
        @(negedge clk);
        check("afterrst control", 32'(control), 32'd0);
        check("afterrst step_idx", 32'(step_idx), 32'd0);
        check("afterrst uop", uop_out, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
